// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_subtractor_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] Difference;
    logic         Borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         Overflow;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Difference, Borrow, Overflow
    );
    modport slave (
        input  start, A, B, Bin,
        output busy, done, Difference, Borrow, Overflow
    );
`else
    modport master (
        output start, A, B, Bin,
        input  busy, done, Difference, Borrow
    );
    modport slave (
        input  start, A, B, Bin,
        output busy, done, Difference, Borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell per clock, LSB first.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_subtractor #(
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       op_a_q, op_a_d;
    logic [N-1:0]       op_b_q, op_b_d;
    logic [N-1:0]       res_q, res_d;
    logic [N-1:0]       diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bor_q, bor_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_a, bit_b, bit_d, bor_nx;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        bit_a  = op_a_q[0];
        bit_b  = op_b_q[0];
        bit_d  = bit_a ^ bit_b ^ bor_q;
        bor_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bor_q);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_a_d  = bus.A;
                    op_b_d  = bus.B;
                    bor_d   = bus.Bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                res_d  = {bit_d, res_q[N-1:1]};
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                bor_d  = bor_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    diff_d   = {bit_d, res_q[N-1:1]};
                    borrow_d = bor_nx;
`ifdef SERIAL_SUB_OVF_EN
                    // bor_q is the borrow into the MSB on this final bit
                    ovf_d    = bor_q ^ bor_nx;
`endif
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.Difference = diff_q;
    assign bus.Borrow     = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.Overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/timing model plus directed vectors.
module tb_serial_subtractor;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: operation phase (0 idle, 1..N shifting, N+1 done) and held results
    int           phase = 0;
    logic [N-1:0] exp_diff = '0;
    logic         exp_bor  = 1'b0;
    logic         exp_ovf  = 1'b0;
    logic [N-1:0] pend_diff;
    logic         pend_bor, pend_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_op(input int a, input int b, input int bin,
                                     output logic [N-1:0] d, output logic bo, output logic ov);
        int r, sa, sb, sr;
        r  = a - b - bin;
        d  = N'(r);
        bo = (r < 0);
        sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
        sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
        sr = sa - sb - bin;
        ov = (sr < -(1 << (N - 1))) || (sr > (1 << (N - 1)) - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase    = 0;
            exp_diff = '0;
            exp_bor  = 1'b0;
            exp_ovf  = 1'b0;
        end else if ((phase == 0 || phase == N + 1) && bus.start) begin
            model_op(int'(bus.A), int'(bus.B), int'(bus.Bin), pend_diff, pend_bor, pend_ovf);
            phase = 1;
        end else if (phase >= 1 && phase <= N) begin
            phase = phase + 1;
            if (phase == N + 1) begin
                exp_diff = pend_diff;
                exp_bor  = pend_bor;
                exp_ovf  = pend_ovf;
            end
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(phase >= 1 && phase <= N));
            check("done", 32'(bus.done), 32'(phase == N + 1));
            check("Difference", 32'(bus.Difference), 32'(exp_diff));
            check("Borrow", 32'(bus.Borrow), 32'(exp_bor));
`ifdef SERIAL_SUB_OVF_EN
            check("Overflow", 32'(bus.Overflow), 32'(exp_ovf));
`endif
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got done=%b expected 1 within 20 cycles", bus.done);
        end
    endtask

    task automatic launch(input int a, input int b, input int bin);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = N'(a);
        bus.B     = N'(b);
        bus.Bin   = 1'(bin);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string name, input int a, input int b, input int bin,
                          input int exp_d, input int exp_b);
        int lat;
        launch(a, b, bin);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat + 1), 32'(N + 1));
        check({name, "_diff"}, 32'(bus.Difference), 32'(exp_d));
        check({name, "_borrow"}, 32'(bus.Borrow), 32'(exp_b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.Difference), 32'd0);
        check("rst_borrow", 32'(bus.Borrow), 32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;

        run_op("t1_9m5", 9, 5, 0, 4, 0);
        run_op("t2_5m9", 5, 9, 0, 12, 1);
        run_op("t3_0m0b", 0, 0, 1, 15, 1);
        run_op("t3_7m7", 7, 7, 0, 0, 0);
        run_op("t_15m0", 15, 0, 0, 15, 0);
        run_op("t_0m15b", 0, 15, 1, 0, 1);

        // Restart attempt two cycles in, and A disturbed mid-operation
        launch(9, 5, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'd1;
        bus.B     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 4'd15;
        wait_done(lat);
        check("t4_remaining", 32'(lat), 32'd2);
        check("t4_diff", 32'(bus.Difference), 32'd4);
        check("t4_borrow", 32'(bus.Borrow), 32'd0);

        // Reset in the middle of a shift
        launch(5, 9, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_diff", 32'(bus.Difference), 32'd0);
        check("t5_borrow", 32'(bus.Borrow), 32'd0);
        run_op("t5_after", 3, 1, 0, 2, 0);

        // Back-to-back: start held high, reload taken in DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'd8;
        bus.B     = 4'd1;
        bus.Bin   = 1'b0;
        @(negedge clk);
        wait_done(lat);
        check("b2b_diff0", 32'(bus.Difference), 32'd7);
`ifdef SERIAL_SUB_OVF_EN
        check("t6_ovf_8m1", 32'(bus.Overflow), 32'd1);
`endif
        bus.A = 4'd3;
        bus.B = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("b2b_lat", 32'(lat + 1), 32'(N + 1));
        check("b2b_diff1", 32'(bus.Difference), 32'd2);
`ifdef SERIAL_SUB_OVF_EN
        check("t6_ovf_3m1", 32'(bus.Overflow), 32'd0);
`endif

        run_op("t_7mneg1", 7, 15, 0, 8, 1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
